issue_scoreboard: RTL and testbench

//   Register scoreboard and issue gate between ID and EXE. Counts in-flight writes per
//   GPR and blocks the ID->EXE handshake while any source the ID instruction reads
//   (RAW) or its destination (counter saturated) has an outstanding write.

---
 rtl/issue_scoreboard_if.sv | 31 +++
 rtl/issue_scoreboard.sv | 133 +++++++++++++
 tb/tb_issue_scoreboard.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/issue_scoreboard_if.sv
// Issue-gate handshake bundle between the ID stage, the EXE stage and the
// retire port of the register scoreboard.
//   master : pipeline side (drives the decoded instruction, EXE ready, retire)
//   slave  : scoreboard side (returns issue_fire / id_ready / hazard)
interface issue_scoreboard_if;
    logic       id_valid;
    logic [4:0] id_rj;
    logic       id_rj_used;
    logic [4:0] id_rk;
    logic       id_rk_used;
    logic       id_wen;
    logic [4:0] id_rd;
    logic       exe_ready;
    logic       issue_fire;
    logic       id_ready;
    logic       hazard;
    logic       wb_en;
    logic [4:0] wb_index;

    modport master (
        output id_valid, id_rj, id_rj_used, id_rk, id_rk_used,
               id_wen, id_rd, exe_ready, wb_en, wb_index,
        input  issue_fire, id_ready, hazard
    );

    modport slave (
        input  id_valid, id_rj, id_rj_used, id_rk, id_rk_used,
               id_wen, id_rd, exe_ready, wb_en, wb_index,
        output issue_fire, id_ready, hazard
    );
endinterface

// File: rtl/issue_scoreboard.sv
// Register scoreboard and ID->EXE issue gate.
// Keeps a saturating pending-write counter per GPR (r0 never tracked) and a
// global in-flight counter. The gate blocks on RAW against any pending write
// and on a destination whose counter is already full.
// Optional feature macro: SCB_WB_BYPASS_EN -- a source (or full destination)
// being retired in the same cycle does not block; forwarding supplies the value.
module issue_scoreboard #(
    parameter int NREG  = 32,
    parameter int CNT_W = 2,
    parameter int TOT_W = 6
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                flush,
    issue_scoreboard_if.slave   sb,
    output logic                sb_empty,
    output logic                sb_err
);

    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [TOT_W-1:0] TOT_ZERO = {TOT_W{1'b0}};
    localparam logic [TOT_W-1:0] TOT_MAX  = {TOT_W{1'b1}};
`ifdef SCB_WB_BYPASS_EN
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
`endif

    logic [CNT_W-1:0] cnt_r      [NREG];
    logic [CNT_W-1:0] cnt_next_s [NREG];
    logic [TOT_W-1:0] total_r;
    logic [TOT_W-1:0] total_next_s;
    logic             sb_empty_r;
    logic             sb_err_r;

    logic [CNT_W-1:0] rj_cnt_s, rk_cnt_s, rd_cnt_s, wb_cnt_s;
    logic             rj_byp_s, rk_byp_s, rd_byp_s;
    logic             raw_s, waw_full_s, hazard_s, fire_s;
    logic             inc_en_s, dec_req_s, same_reg_s;
    logic             underflow_s, overflow_s, tot_inc_s, tot_dec_s;

    // Hazard detection and the zero-latency issue handshake.
    always_comb begin
        rj_cnt_s = cnt_r[sb.id_rj];
        rk_cnt_s = cnt_r[sb.id_rk];
        rd_cnt_s = cnt_r[sb.id_rd];
`ifdef SCB_WB_BYPASS_EN
        // The last outstanding write retiring now is forwarded, so it no longer blocks.
        rj_byp_s = sb.wb_en && (sb.wb_index == sb.id_rj) && (rj_cnt_s == CNT_ONE);
        rk_byp_s = sb.wb_en && (sb.wb_index == sb.id_rk) && (rk_cnt_s == CNT_ONE);
        // A retire to the full destination frees a slot in the same cycle.
        rd_byp_s = sb.wb_en && (sb.wb_index == sb.id_rd);
`else
        rj_byp_s = 1'b0;
        rk_byp_s = 1'b0;
        rd_byp_s = 1'b0;
`endif
        raw_s = (sb.id_rj_used && (sb.id_rj != 5'd0) && (rj_cnt_s != CNT_ZERO) && !rj_byp_s) ||
                (sb.id_rk_used && (sb.id_rk != 5'd0) && (rk_cnt_s != CNT_ZERO) && !rk_byp_s);
        waw_full_s = sb.id_wen && (sb.id_rd != 5'd0) && (rd_cnt_s == CNT_MAX) && !rd_byp_s;
        hazard_s   = sb.id_valid && (raw_s || waw_full_s);
        // Nothing may enter EXE in a flush cycle.
        fire_s     = sb.id_valid && sb.exe_ready && !hazard_s && !flush;
    end

    assign sb.hazard     = hazard_s;
    assign sb.id_ready   = sb.exe_ready && !hazard_s;
    assign sb.issue_fire = fire_s;
    assign sb_empty      = sb_empty_r;
    assign sb_err        = sb_err_r;

    // Next-state computation for the per-register and global counters.
    always_comb begin
        inc_en_s    = fire_s && sb.id_wen && (sb.id_rd != 5'd0);
        dec_req_s   = sb.wb_en && (sb.wb_index != 5'd0);
        wb_cnt_s    = cnt_r[sb.wb_index];
        // Issue and retire to the same register cancel out.
        same_reg_s  = inc_en_s && dec_req_s && (sb.id_rd == sb.wb_index);
        underflow_s = dec_req_s && (wb_cnt_s == CNT_ZERO);
        tot_inc_s   = inc_en_s && !same_reg_s;
        tot_dec_s   = dec_req_s && !same_reg_s && !underflow_s;

        for (int i = 0; i < NREG; i++) begin
            if (i == 0) begin
                cnt_next_s[i] = CNT_ZERO;
            end else if (tot_inc_s && (sb.id_rd == 5'(i))) begin
                cnt_next_s[i] = cnt_r[i] + CNT_W'(1);
            end else if (tot_dec_s && (sb.wb_index == 5'(i))) begin
                cnt_next_s[i] = cnt_r[i] - CNT_W'(1);
            end else begin
                cnt_next_s[i] = cnt_r[i];
            end
        end

        overflow_s = 1'b0;
        if (tot_inc_s && !tot_dec_s) begin
            if (total_r == TOT_MAX) begin
                overflow_s   = 1'b1;
                total_next_s = total_r;
            end else begin
                total_next_s = total_r + TOT_W'(1);
            end
        end else if (tot_dec_s && !tot_inc_s && (total_r != TOT_ZERO)) begin
            total_next_s = total_r - TOT_W'(1);
        end else begin
            total_next_s = total_r;
        end
    end

    // State registers: reset clears everything, flush clears pending state but keeps sb_err.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREG; i++) begin
                cnt_r[i] <= CNT_ZERO;
            end
            total_r    <= TOT_ZERO;
            sb_empty_r <= 1'b1;
            sb_err_r   <= 1'b0;
        end else if (flush) begin
            for (int i = 0; i < NREG; i++) begin
                cnt_r[i] <= CNT_ZERO;
            end
            total_r    <= TOT_ZERO;
            sb_empty_r <= 1'b1;
            sb_err_r   <= sb_err_r;
        end else begin
            cnt_r      <= cnt_next_s;
            total_r    <= total_next_s;
            sb_empty_r <= (total_next_s == TOT_ZERO);
            sb_err_r   <= sb_err_r || underflow_s || overflow_s;
        end
    end

endmodule

// File: tb/tb_issue_scoreboard.sv
// Directed self-checking bench for issue_scoreboard.
// Inputs change 1ns after the rising edge; combinational outputs are sampled
// 1ns later, registered ones 1ns after the following edge.
module tb_issue_scoreboard;

    logic clk;
    logic reset;
    logic flush;
    logic sb_empty;
    logic sb_err;
    int   n_checks;
    int   n_errors;

    issue_scoreboard_if bus ();

    issue_scoreboard #(.NREG(32), .CNT_W(2), .TOT_W(6)) dut (
        .clk      (clk),
        .reset    (reset),
        .flush    (flush),
        .sb       (bus),
        .sb_empty (sb_empty),
        .sb_err   (sb_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle();
        bus.id_valid   = 1'b0;
        bus.id_rj      = 5'd0;
        bus.id_rj_used = 1'b0;
        bus.id_rk      = 5'd0;
        bus.id_rk_used = 1'b0;
        bus.id_wen     = 1'b0;
        bus.id_rd      = 5'd0;
        bus.exe_ready  = 1'b1;
        bus.wb_en      = 1'b0;
        bus.wb_index   = 5'd0;
        flush          = 1'b0;
    endtask

    task automatic drive_issue(input logic [4:0] rd);
        set_idle();
        bus.id_valid = 1'b1;
        bus.id_wen   = 1'b1;
        bus.id_rd    = rd;
    endtask

    task automatic test_reset();
        set_idle();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        #1;
        n_checks++; if (sb_empty !== 1'b1) begin n_errors++; $display("FAIL reset_empty: got %b exp 1", sb_empty); end
        n_checks++; if (sb_err !== 1'b0) begin n_errors++; $display("FAIL reset_err: got %b exp 0", sb_err); end
        n_checks++; if (bus.hazard !== 1'b0) begin n_errors++; $display("FAIL reset_hazard: got %b exp 0", bus.hazard); end
    endtask

    task automatic test_issue_basic();
        drive_issue(5'd5);
        #1;
        n_checks++; if (bus.issue_fire !== 1'b1) begin n_errors++; $display("FAIL t1_fire: got %b exp 1", bus.issue_fire); end
        tick();
        set_idle();
        #1;
        n_checks++; if (dut.cnt_r[5] !== 2'd1) begin n_errors++; $display("FAIL t1_cnt5: got %0d exp 1", dut.cnt_r[5]); end
        n_checks++; if (sb_empty !== 1'b0) begin n_errors++; $display("FAIL t1_empty: got %b exp 0", sb_empty); end
    endtask

    task automatic test_raw();
        drive_issue(5'd10);
        bus.id_rj      = 5'd5;
        bus.id_rj_used = 1'b1;
        #1;
        n_checks++; if (bus.hazard !== 1'b1) begin n_errors++; $display("FAIL t2_hazard: got %b exp 1", bus.hazard); end
        n_checks++; if (bus.id_ready !== 1'b0) begin n_errors++; $display("FAIL t2_ready: got %b exp 0", bus.id_ready); end
        tick();
        bus.wb_en    = 1'b1;
        bus.wb_index = 5'd5;
        #1;
`ifdef SCB_WB_BYPASS_EN
        n_checks++; if (bus.issue_fire !== 1'b1) begin n_errors++; $display("FAIL t2_wb_cycle_fire: got %b exp 1", bus.issue_fire); end
`else
        n_checks++; if (bus.issue_fire !== 1'b0) begin n_errors++; $display("FAIL t2_wb_cycle_fire: got %b exp 0", bus.issue_fire); end
`endif
        tick();
        bus.wb_en = 1'b0;
`ifdef SCB_WB_BYPASS_EN
        bus.id_valid = 1'b0;
`else
        #1;
        n_checks++; if (bus.issue_fire !== 1'b1) begin n_errors++; $display("FAIL t2_next_fire: got %b exp 1", bus.issue_fire); end
`endif
        tick();
        set_idle();
        #1;
        n_checks++; if (dut.cnt_r[5] !== 2'd0) begin n_errors++; $display("FAIL t2_cnt5: got %0d exp 0", dut.cnt_r[5]); end
        n_checks++; if (dut.cnt_r[10] !== 2'd1) begin n_errors++; $display("FAIL t2_cnt10: got %0d exp 1", dut.cnt_r[10]); end
        bus.wb_en    = 1'b1;
        bus.wb_index = 5'd10;
        tick();
        set_idle();
        #1;
        n_checks++; if (sb_empty !== 1'b1) begin n_errors++; $display("FAIL t2_empty: got %b exp 1", sb_empty); end
    endtask

    task automatic test_waw_full();
        for (int k = 0; k < 3; k++) begin
            drive_issue(5'd7);
            #1;
            n_checks++; if (bus.issue_fire !== 1'b1) begin n_errors++; $display("FAIL t3_fire%0d: got %b exp 1", k, bus.issue_fire); end
            tick();
        end
        set_idle();
        #1;
        n_checks++; if (dut.cnt_r[7] !== 2'd3) begin n_errors++; $display("FAIL t3_cnt7: got %0d exp 3", dut.cnt_r[7]); end
        drive_issue(5'd7);
        #1;
        n_checks++; if (bus.hazard !== 1'b1) begin n_errors++; $display("FAIL t3_full_hazard: got %b exp 1", bus.hazard); end
        tick();
        n_checks++; if (bus.id_ready !== 1'b0) begin n_errors++; $display("FAIL t3_full_ready: got %b exp 0", bus.id_ready); end
        bus.wb_en    = 1'b1;
        bus.wb_index = 5'd7;
        #1;
`ifdef SCB_WB_BYPASS_EN
        n_checks++; if (bus.hazard !== 1'b0) begin n_errors++; $display("FAIL t3_wb_hazard: got %b exp 0", bus.hazard); end
        tick();
        bus.id_valid = 1'b0;
        bus.wb_en    = 1'b0;
`else
        n_checks++; if (bus.hazard !== 1'b1) begin n_errors++; $display("FAIL t3_wb_hazard: got %b exp 1", bus.hazard); end
        tick();
        bus.wb_en = 1'b0;
        #1;
        n_checks++; if (bus.issue_fire !== 1'b1) begin n_errors++; $display("FAIL t3_after_wb_fire: got %b exp 1", bus.issue_fire); end
`endif
        tick();
        set_idle();
        #1;
        n_checks++; if (dut.cnt_r[7] !== 2'd3) begin n_errors++; $display("FAIL t3_cnt7_end: got %0d exp 3", dut.cnt_r[7]); end
        bus.wb_en    = 1'b1;
        bus.wb_index = 5'd7;
        tick();
        tick();
        tick();
        set_idle();
        #1;
        n_checks++; if (sb_empty !== 1'b1) begin n_errors++; $display("FAIL t3_empty: got %b exp 1", sb_empty); end
    endtask

    task automatic test_same_cycle();
        drive_issue(5'd9);
        tick();
        bus.wb_en    = 1'b1;
        bus.wb_index = 5'd9;
        #1;
        n_checks++; if (bus.issue_fire !== 1'b1) begin n_errors++; $display("FAIL t4_fire: got %b exp 1", bus.issue_fire); end
        tick();
        set_idle();
        #1;
        n_checks++; if (dut.cnt_r[9] !== 2'd1) begin n_errors++; $display("FAIL t4_cnt9: got %0d exp 1", dut.cnt_r[9]); end
        n_checks++; if (dut.total_r !== 6'd1) begin n_errors++; $display("FAIL t4_total: got %0d exp 1", dut.total_r); end
        bus.wb_en    = 1'b1;
        bus.wb_index = 5'd9;
        tick();
        set_idle();
    endtask

    task automatic test_r0();
        drive_issue(5'd0);
        bus.id_rj_used = 1'b1;
        bus.id_rk_used = 1'b1;
        bus.wb_en      = 1'b1;
        bus.wb_index   = 5'd0;
        #1;
        n_checks++; if (bus.hazard !== 1'b0) begin n_errors++; $display("FAIL t5_r0_hazard: got %b exp 0", bus.hazard); end
        tick();
        tick();
        set_idle();
        #1;
        n_checks++; if (sb_empty !== 1'b1) begin n_errors++; $display("FAIL t5_r0_empty: got %b exp 1", sb_empty); end
        n_checks++; if (sb_err !== 1'b0) begin n_errors++; $display("FAIL t5_r0_err: got %b exp 0", sb_err); end
        bus.wb_en    = 1'b1;
        bus.wb_index = 5'd3;
        tick();
        set_idle();
        tick();
        n_checks++; if (sb_err !== 1'b1) begin n_errors++; $display("FAIL t5_underflow_err: got %b exp 1", sb_err); end
        n_checks++; if (dut.cnt_r[3] !== 2'd0) begin n_errors++; $display("FAIL t5_cnt3: got %0d exp 0", dut.cnt_r[3]); end
        n_checks++; if (sb_empty !== 1'b1) begin n_errors++; $display("FAIL t5_empty: got %b exp 1", sb_empty); end
    endtask

    task automatic test_flush();
        drive_issue(5'd4);
        tick();
        tick();
        drive_issue(5'd6);
        tick();
        drive_issue(5'd8);
        flush = 1'b1;
        #1;
        n_checks++; if (bus.issue_fire !== 1'b0) begin n_errors++; $display("FAIL t6_flush_fire: got %b exp 0", bus.issue_fire); end
        tick();
        set_idle();
        #1;
        n_checks++; if (dut.cnt_r[4] !== 2'd0) begin n_errors++; $display("FAIL t6_cnt4: got %0d exp 0", dut.cnt_r[4]); end
        n_checks++; if (dut.cnt_r[6] !== 2'd0) begin n_errors++; $display("FAIL t6_cnt6: got %0d exp 0", dut.cnt_r[6]); end
        n_checks++; if (sb_empty !== 1'b1) begin n_errors++; $display("FAIL t6_empty: got %b exp 1", sb_empty); end
        n_checks++; if (sb_err !== 1'b1) begin n_errors++; $display("FAIL t6_err_held: got %b exp 1", sb_err); end
    endtask

    task automatic test_reset_mid();
        drive_issue(5'd12);
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        set_idle();
        #1;
        n_checks++; if (sb_empty !== 1'b1) begin n_errors++; $display("FAIL rst_mid_empty: got %b exp 1", sb_empty); end
        n_checks++; if (sb_err !== 1'b0) begin n_errors++; $display("FAIL rst_mid_err: got %b exp 0", sb_err); end
        n_checks++; if (dut.cnt_r[12] !== 2'd0) begin n_errors++; $display("FAIL rst_mid_cnt12: got %0d exp 0", dut.cnt_r[12]); end
    endtask

    task automatic test_total_sat();
        for (int r = 1; r <= 21; r++) begin
            for (int k = 0; k < 3; k++) begin
                drive_issue(5'(r));
                tick();
            end
        end
        set_idle();
        #1;
        n_checks++; if (dut.total_r !== 6'd63) begin n_errors++; $display("FAIL tot_full: got %0d exp 63", dut.total_r); end
        n_checks++; if (sb_err !== 1'b0) begin n_errors++; $display("FAIL tot_full_err: got %b exp 0", sb_err); end
        drive_issue(5'd22);
        #1;
        n_checks++; if (bus.issue_fire !== 1'b1) begin n_errors++; $display("FAIL tot_ovf_fire: got %b exp 1", bus.issue_fire); end
        tick();
        set_idle();
        #1;
        n_checks++; if (dut.total_r !== 6'd63) begin n_errors++; $display("FAIL tot_sat: got %0d exp 63", dut.total_r); end
        n_checks++; if (sb_err !== 1'b1) begin n_errors++; $display("FAIL tot_ovf_err: got %b exp 1", sb_err); end
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        reset    = 1'b1;
        set_idle();
        test_reset();
        test_issue_basic();
        test_raw();
        test_waw_full();
        test_same_cycle();
        test_r0();
        test_flush();
        test_reset_mid();
        test_total_sat();
        test_reset();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
